// File: rtl/bnn_input_loader.sv
// Writer side of the BNN input-SRAM image format: packs a 1-bit pixel stream into
// LSB-first row words, framing each image with a size header and the list with an end marker.
module bnn_input_loader #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4096,
  parameter logic [DATA_W-1:0] END_MARK = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              img_valid,
  input  logic [4:0]        img_size,
  output logic              img_ready,
  input  logic              pix_valid,
  input  logic              pix_bit,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_wr_enable
);

  localparam int SUM_W = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HDR,
    S_WR_HDR,
    S_COLLECT,
    S_WR_ROW,
    S_WR_END,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] wptr;
  logic [4:0]        n_q;
  logic [4:0]        row;
  logic [4:0]        col;
  logic [DATA_W-1:0] shreg;
  logic              err_q;

  logic [SUM_W-1:0]  need;
  logic              size_ok;
  logic              hdr_fits;
  logic              hdr_ok;
  logic              last_col;
  logic              last_row;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] row_mask;

  // Room must remain for the header, N rows and the terminator.
  assign need       = SUM_W'(wptr) + SUM_W'(img_size) + SUM_W'(1);
  assign hdr_fits   = (need <= SUM_W'(DEPTH - 1));
  assign size_ok    = (img_size == 5'd10) || (img_size == 5'd12) || (img_size == 5'd16);
  assign hdr_ok     = size_ok && hdr_fits;
  assign last_col   = (col == n_q - 5'd1);
  assign last_row   = (row == n_q - 5'd1);
  assign shreg_next = shreg | (DATA_W'(pix_bit) << col);
  assign row_mask   = (DATA_W'(1) << n_q) - DATA_W'(1);
  assign err        = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    busy           = 1'b0;
    done           = 1'b0;
    img_ready      = 1'b0;
    pix_ready      = 1'b0;
    sram_wr_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_WAIT_HDR;
      end
      S_WAIT_HDR: begin
        busy      = 1'b1;
        img_ready = ~finish;
        if (finish) begin
          state_next = S_WR_END;
        end else if (img_valid && hdr_ok) begin
          state_next = S_WR_HDR;
        end
      end
      S_WR_HDR: begin
        busy           = 1'b1;
        sram_wr_enable = 1'b1;
        state_next     = S_COLLECT;
      end
      S_COLLECT: begin
        busy      = 1'b1;
        pix_ready = 1'b1;
        if (pix_valid && last_col) state_next = S_WR_ROW;
      end
      S_WR_ROW: begin
        busy           = 1'b1;
        sram_wr_enable = 1'b1;
        state_next     = last_row ? S_WAIT_HDR : S_COLLECT;
      end
      S_WR_END: begin
        busy           = 1'b1;
        sram_wr_enable = 1'b1;
        state_next     = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address/data are loaded on entry to each write state so they line up with the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr               <= '0;
      n_q                <= '0;
      row                <= '0;
      col                <= '0;
      shreg              <= '0;
      err_q              <= 1'b0;
      sram_write_address <= '0;
      sram_write_data    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) wptr <= '0;
        end
        S_WAIT_HDR: begin
          if (finish) begin
            sram_write_address <= wptr;
            sram_write_data    <= END_MARK;
          end else if (img_valid) begin
            if (hdr_ok) begin
              n_q                <= img_size;
              sram_write_address <= wptr;
              sram_write_data    <= DATA_W'(img_size);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WR_HDR: begin
          wptr  <= wptr + ADDR_W'(1);
          row   <= '0;
          col   <= '0;
          shreg <= '0;
        end
        S_COLLECT: begin
          if (pix_valid) begin
            shreg <= shreg_next;
            col   <= col + 5'd1;
            if (last_col) begin
              sram_write_address <= wptr;
              sram_write_data    <= shreg_next & row_mask;
            end
          end
        end
        S_WR_ROW: begin
          wptr  <= wptr + ADDR_W'(1);
          shreg <= '0;
          col   <= '0;
          if (!last_row) row <= row + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_input_loader.sv
// Randomized scoreboard bench for bnn_input_loader: stimulus pushes expected SRAM writes,
// a negedge monitor pops and compares them as the DUT strobes sram_wr_enable.
module tb_bnn_input_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        img_valid = 1'b0;
  logic [4:0]  img_size = '0;
  logic        pix_valid = 1'b0;
  logic        pix_bit = 1'b0;
  logic        busy, done, err, img_ready, pix_ready, sram_wr_enable;
  logic [11:0] sram_write_address;
  logic [15:0] sram_write_data;

  int          total = 0;
  int          bad = 0;
  int          m_wptr = 0;
  int          err_exp = 0, err_seen = 0;
  int          done_exp = 0, done_seen = 0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_e;
  logic [15:0] img_rows[16];

  bnn_input_loader dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .busy(busy), .done(done), .err(err),
    .img_valid(img_valid), .img_size(img_size), .img_ready(img_ready),
    .pix_valid(pix_valid), .pix_bit(pix_bit), .pix_ready(pix_ready),
    .sram_write_address(sram_write_address), .sram_write_data(sram_write_data),
    .sram_wr_enable(sram_wr_enable)
  );

  always #5 clk = ~clk;

  task automatic check_val(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitor: every write strobe consumes one expected {address,data} entry.
  always @(negedge clk) begin
    if (reset) begin
      if (sram_wr_enable) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected none",
                   sram_write_address, sram_write_data);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("wr_addr", int'(sram_write_address), int'(mon_e[27:16]));
          check_val("wr_data", int'(sram_write_data), int'(mon_e[15:0]));
        end
      end
      if (err) err_seen++;
      if (done) done_seen++;
      check_val("ready_exclusive", int'(img_ready & pix_ready), 0);
    end
  end

  function automatic logic [15:0] mask_of(int n);
    return (n >= 16) ? 16'hFFFF : 16'((1 << n) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(int n);
    for (int r = 0; r < 16; r++) img_rows[r] = 16'($urandom) & mask_of(n);
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_wptr = 0;
    check_val("busy_after_start", int'(busy), 1);
    check_val("img_ready_in_wait", int'(img_ready), 1);
  endtask

  // Reference rule: legal sizes only, and header + N rows + terminator must fit below DEPTH-1.
  task automatic send_header(input int n, output bit accepted);
    bit got;
    got = 1'b0;
    accepted = 1'b0;
    img_valid = 1'b1;
    img_size = 5'(n);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      got = img_ready;
      tick();
      if (got) break;
    end
    img_valid = 1'b0;
    if (!got) begin
      timeout_fail("header_handshake");
    end else if ((n == 10 || n == 12 || n == 16) && (m_wptr + n + 1 <= 4095)) begin
      exp_q.push_back({12'(m_wptr), 16'(n)});
      m_wptr++;
      accepted = 1'b1;
    end else begin
      err_exp++;
    end
  endtask

  task automatic send_image(int n, int gap, int nrows, int extra);
    bit got;
    for (int r = 0; r <= nrows; r++) begin
      for (int c = 0; c < n; c++) begin
        if (r == nrows && c >= extra) break;
        while ($urandom_range(0, 99) < gap) begin
          pix_valid = 1'b0;
          start = ($urandom_range(0, 7) == 0);
          tick();
        end
        start = 1'b0;
        pix_valid = 1'b1;
        pix_bit = img_rows[r][c];
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          got = pix_ready;
          tick();
          if (got) break;
        end
        pix_valid = 1'b0;
        if (!got) timeout_fail("pixel_handshake");
      end
      if (r < nrows) begin
        exp_q.push_back({12'(m_wptr), img_rows[r] & mask_of(n)});
        m_wptr++;
        check_val("row_bubble", int'(pix_ready), 0);
      end
    end
  endtask

  task automatic finish_load(bit with_hdr);
    bit got;
    finish = 1'b1;
    img_valid = with_hdr;
    img_size = 5'd16;
    exp_q.push_back({12'(m_wptr), 16'h00FF});
    done_exp++;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      got = done;
      tick();
      if (got) break;
    end
    finish = 1'b0;
    img_valid = 1'b0;
    if (!got) timeout_fail("done_pulse");
    check_val("busy_after_done", int'(busy), 0);
  endtask

  task automatic check_counts();
    repeat (3) tick();
    check_val("err_count", err_seen, err_exp);
    check_val("done_count", done_seen, done_exp);
    check_val("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int sizes[7] = '{10, 12, 16, 11, 0, 31, 15};
    int n;
    repeat (3) tick();
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_wr_enable", int'(sram_wr_enable), 0);
    reset = 1'b1;
    tick();

    $display("[TB] scenario 1: single 10x10 image");
    start_load();
    send_header(10, acc);
    for (int r = 0; r < 16; r++) img_rows[r] = (r % 2 == 1) ? 16'h03FF : 16'h0000;
    send_image(10, 0, 10, 0);
    finish_load(1'b0);
    check_counts();

    $display("[TB] scenario 2: 16x16 with 50 percent valid");
    start_load();
    send_header(16, acc);
    for (int r = 0; r < 16; r++) img_rows[r] = 16'h8001;
    send_image(16, 50, 16, 0);
    finish_load(1'b0);
    check_counts();

    $display("[TB] scenario 3: illegal size then legal");
    start_load();
    send_header(11, acc);
    check_val("err_pulse_size", int'(err), 1);
    check_val("img_ready_after_err", int'(img_ready), 1);
    send_header(12, acc);
    fill_random(12);
    send_image(12, 20, 12, 0);
    finish_load(1'b0);
    check_counts();

    $display("[TB] scenario 4: fill to 4080 then overflow header");
    start_load();
    for (int i = 0; i < 370; i++) begin
      n = (i < 365) ? 10 : 12;
      send_header(n, acc);
      fill_random(n);
      send_image(n, 0, n, 0);
    end
    send_header(16, acc);
    check_val("err_pulse_space", int'(err), 1);
    finish_load(1'b0);
    check_counts();

    $display("[TB] scenario 5: reset mid-row");
    start_load();
    send_header(10, acc);
    fill_random(10);
    send_image(10, 10, 3, 5);
    reset = 1'b0;
    #1;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_err", int'(err), 0);
    check_val("rst_img_ready", int'(img_ready), 0);
    check_val("rst_pix_ready", int'(pix_ready), 0);
    check_val("rst_wr_enable", int'(sram_wr_enable), 0);
    check_val("rst_addr", int'(sram_write_address), 0);
    check_val("rst_data", int'(sram_write_data), 0);
    check_val("pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    start_load();
    send_header(10, acc);
    fill_random(10);
    send_image(10, 30, 10, 0);
    finish_load(1'b0);
    check_counts();

    $display("[TB] scenario 6: back to back 12/10/16, finish with header offer");
    start_load();
    send_header(12, acc);
    fill_random(12);
    send_image(12, 20, 12, 0);
    send_header(10, acc);
    fill_random(10);
    send_image(10, 20, 10, 0);
    send_header(16, acc);
    fill_random(16);
    send_image(16, 20, 16, 0);
    finish_load(1'b1);
    check_counts();

    $display("[TB] random loads");
    for (int l = 0; l < 6; l++) begin
      start_load();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        n = sizes[$urandom_range(0, 6)];
        send_header(n, acc);
        if (acc) begin
          fill_random(n);
          send_image(n, int'($urandom_range(0, 60)), n, 0);
        end
      end
      finish_load(1'($urandom_range(0, 1)));
      check_counts();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
